// File: rtl/divmod_pkg.sv
// Shared types and defaults for the iterative divider.
// Ports: none (package). State encoding and default operand width.
// Optional signed support in divmod_unit is controlled by macro DIVMOD_SIGNED_EN.
package divmod_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } divmod_state_t;

  localparam int DIVMOD_DEFAULT_W = 8;

endpackage

// File: rtl/divmod_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract.
// Ports: i_rem/i_msb/i_dsr in; o_rem (next partial remainder), o_qbit (quotient bit) out.
// Latency: combinational; no handshake.
module divmod_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_rem,
  input  logic         i_msb,
  input  logic [W-1:0] i_dsr,
  output logic [W-1:0] o_rem,
  output logic         o_qbit
);

  logic [W:0] w_shift;
  logic [W:0] w_diff;

  // The shifted remainder needs W+1 bits: rem < divisor <= 2^W-1, so 2*rem+1 can exceed W bits.
  assign w_shift = {i_rem, i_msb};
  assign w_diff  = w_shift - {1'b0, i_dsr};

  // |w_shift - divisor| < 2^W, so bit W of the difference is a clean borrow flag.
  assign o_qbit = ~w_diff[W];
  assign o_rem  = o_qbit ? w_diff[W-1:0] : w_shift[W-1:0];

endmodule

// File: rtl/divmod_unit.sv
// Iterative restoring divider returning quotient and remainder, one quotient bit per clock.
// Ports: clk/rst_n; in_valid/in_ready + operands + in_signed; out_valid/out_ready + results + div-by-zero flag.
// Latency DATA_WIDTH edges after accept (div-by-zero: result registered on the accept edge); in_ready only in IDLE.
// Macro DIVMOD_SIGNED_EN adds two's-complement operation selected by in_signed.
module divmod_unit
  import divmod_pkg::*;
#(
  parameter int DATA_WIDTH = DIVMOD_DEFAULT_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_dividend,
  input  logic [DATA_WIDTH-1:0] in_divisor,
  input  logic                  in_signed,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_quotient,
  output logic [DATA_WIDTH-1:0] out_remainder,
  output logic                  out_div_by_zero
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  divmod_state_t r_state, w_state_nxt;

  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_dvd, r_dsr, r_rem, r_quo;
  logic [W-1:0]     r_q_out, r_r_out;
  logic             r_dbz;

  logic             w_dsr_zero, w_last, w_qbit;
  logic [W-1:0]     w_rem_nxt, w_quo_nxt;
  logic [W-1:0]     w_dvd_mag, w_dsr_mag, w_q_fin, w_r_fin;

  assign w_dsr_zero = (in_divisor == '0);
  assign w_last     = (r_cnt == CNT_W'(W - 1));
  assign w_quo_nxt  = {r_quo[W-2:0], w_qbit};

  divmod_step #(.W(W)) u_step (
    .i_rem  (r_rem),
    .i_msb  (r_dvd[W-1]),
    .i_dsr  (r_dsr),
    .o_rem  (w_rem_nxt),
    .o_qbit (w_qbit)
  );

`ifdef DIVMOD_SIGNED_EN
  logic w_dvd_neg, w_dsr_neg;
  logic r_neg_q, r_neg_r;

  assign w_dvd_neg = in_signed & in_dividend[W-1];
  assign w_dsr_neg = in_signed & in_divisor[W-1];
  assign w_dvd_mag = w_dvd_neg ? -in_dividend : in_dividend;
  assign w_dsr_mag = w_dsr_neg ? -in_divisor  : in_divisor;

  // MIN/-1 needs no special case: |MIN| read as unsigned divided by 1 gives MIN, signs agree.
  assign w_q_fin = r_neg_q ? -w_quo_nxt : w_quo_nxt;
  assign w_r_fin = r_neg_r ? -w_rem_nxt : w_rem_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (r_state == IDLE && in_valid) begin
      r_neg_q <= w_dvd_neg ^ w_dsr_neg;
      r_neg_r <= w_dvd_neg;
    end
  end
`else
  logic w_unused_signed;

  assign w_unused_signed = in_signed;
  assign w_dvd_mag       = in_dividend;
  assign w_dsr_mag       = in_divisor;
  assign w_q_fin         = w_quo_nxt;
  assign w_r_fin         = w_rem_nxt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = w_dsr_zero ? DONE : CALC;
      end
      CALC: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dsr   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_q_out <= '0;
      r_r_out <= '0;
      r_dbz   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_dvd <= w_dvd_mag;
            r_dsr <= w_dsr_mag;
            r_rem <= '0;
            r_quo <= '0;
            r_cnt <= '0;
            r_dbz <= w_dsr_zero;
            // Divide-by-zero skips CALC, so its result is registered right here.
            if (w_dsr_zero) begin
              r_q_out <= '1;
              r_r_out <= in_dividend;
            end
          end
        end
        CALC: begin
          r_dvd <= r_dvd << 1;
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_q_out <= w_q_fin;
            r_r_out <= w_r_fin;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_quotient    = r_q_out;
  assign out_remainder   = r_r_out;
  assign out_div_by_zero = r_dbz;

endmodule

// File: tb/tb_divmod_unit.sv
module tb_divmod_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_signed;
  logic [7:0] in_dividend, in_divisor;
  logic       out_valid, out_ready, out_div_by_zero;
  logic [7:0] out_quotient, out_remainder;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  divmod_unit #(.DATA_WIDTH(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_dividend     (in_dividend),
    .in_divisor      (in_divisor),
    .in_signed       (in_signed),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_quotient    (out_quotient),
    .out_remainder   (out_remainder),
    .out_div_by_zero (out_div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation and wait for its result. lat = edges after the accept edge until out_valid.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        output int lat, output logic [7:0] q, output logic [7:0] r,
                        output logic z, output int acc_cyc);
    int n;
    in_dividend = a;
    in_divisor  = b;
    in_signed   = s;
    in_valid    = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    // Scramble operands after the accept edge; the result must not depend on them.
    in_valid    = 1'b0;
    in_dividend = ~a;
    in_divisor  = ~b;
    in_signed   = ~s;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    q = out_quotient;
    r = out_remainder;
    z = out_div_by_zero;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat, acc1, acc2;
    logic [7:0] q, r, q2, r2;
    logic       z, z2, stable;

    rst_n = 1'b0; in_valid = 1'b0; in_signed = 1'b0;
    in_dividend = 8'd0; in_divisor = 8'd0; out_ready = 1'b1;

    tbl.push_back('{8'd100, 8'd7,   1'b0, 8'd14,  8'd2,   1'b0});
    tbl.push_back('{8'd5,   8'd0,   1'b0, 8'hFF,  8'd5,   1'b1});
    tbl.push_back('{8'd9,   8'd3,   1'b0, 8'd3,   8'd0,   1'b0});
    tbl.push_back('{8'd255, 8'd255, 1'b0, 8'd1,   8'd0,   1'b0});
    tbl.push_back('{8'd254, 8'd255, 1'b0, 8'd0,   8'd254, 1'b0});
    tbl.push_back('{8'd0,   8'd5,   1'b0, 8'd0,   8'd0,   1'b0});
    tbl.push_back('{8'd128, 8'd16,  1'b0, 8'd8,   8'd0,   1'b0});
    tbl.push_back('{8'd0,   8'd0,   1'b0, 8'hFF,  8'd0,   1'b1});
    tbl.push_back('{8'd250, 8'd128, 1'b0, 8'd1,   8'd122, 1'b0});
`ifdef DIVMOD_SIGNED_EN
    tbl.push_back('{8'hF9,  8'd2,   1'b1, 8'hFD,  8'hFF,  1'b0});
    tbl.push_back('{8'h80,  8'hFF,  1'b1, 8'h80,  8'h00,  1'b0});
    tbl.push_back('{8'hF9,  8'd2,   1'b0, 8'd124, 8'd1,   1'b0});
    tbl.push_back('{8'd7,   8'hFE,  1'b1, 8'hFD,  8'd1,   1'b0});
    tbl.push_back('{8'hF9,  8'hFE,  1'b1, 8'd3,   8'hFF,  1'b0});
    tbl.push_back('{8'hF9,  8'd0,   1'b1, 8'hFF,  8'hF9,  1'b1});
`endif

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient",  32'(out_quotient), 32'd0);
    chk("rst_remainder", 32'(out_remainder), 32'd0);
    chk("rst_dbz",       32'(out_div_by_zero), 32'd0);
    chk("rst_in_ready",  32'(in_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vector table
    foreach (tbl[i]) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].s, lat, q, r, z, acc1);
      chk($sformatf("vec%0d_q", i), 32'(q), 32'(tbl[i].q));
      chk($sformatf("vec%0d_r", i), 32'(r), 32'(tbl[i].r));
      chk($sformatf("vec%0d_dbz", i), 32'(z), 32'(tbl[i].z));
      chk($sformatf("vec%0d_latency", i), 32'(lat), tbl[i].z ? 32'd0 : 32'd8);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_consumed", i), 32'(out_valid), 32'd0);
    end

    // Back-to-back throughput with out_ready held high
    run_op(8'd255, 8'd1, 1'b0, lat, q, r, z, acc1);
    run_op(8'd3, 8'd200, 1'b0, lat, q2, r2, z2, acc2);
    chk("b2b_q1", 32'(q), 32'd255);
    chk("b2b_r1", 32'(r), 32'd0);
    chk("b2b_q2", 32'(q2), 32'd0);
    chk("b2b_r2", 32'(r2), 32'd3);
    chk("b2b_accept_gap", 32'(acc2 - acc1), 32'd10);
    @(posedge clk); #1;

    // Backpressure: result must hold, busy inputs ignored
    out_ready = 1'b0;
    run_op(8'd200, 8'd9, 1'b0, lat, q, r, z, acc1);
    chk("bp_q", 32'(q), 32'd22);
    chk("bp_r", 32'(r), 32'd2);
    chk("bp_latency", 32'(lat), 32'd8);
    stable = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in_valid = k[0]; in_dividend = 8'd1; in_divisor = 8'd1;
      @(posedge clk); #1;
      if (out_quotient !== 8'd22 || out_remainder !== 8'd2 || out_valid !== 1'b1 || in_ready !== 1'b0)
        stable = 1'b0;
    end
    chk("bp_stable", 32'(stable), 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(out_valid), 32'd0);
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_no_queued_op", 32'(out_valid), 32'd0);

    // Reset in the middle of a calculation
    in_dividend = 8'd77; in_divisor = 8'd5; in_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_quotient",  32'(out_quotient), 32'd0);
    chk("midrst_remainder", 32'(out_remainder), 32'd0);
    chk("midrst_valid",     32'(out_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    run_op(8'd77, 8'd5, 1'b0, lat, q, r, z, acc1);
    chk("midrst_next_q", 32'(q), 32'd15);
    chk("midrst_next_r", 32'(r), 32'd2);
    chk("midrst_next_dbz", 32'(z), 32'd0);
    @(posedge clk); #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
